rx_axis_framer: RTL and testbench
=================================

# rx_axis_framer

Byte-stream packetiser between the DeFEC output (`m_axis_tdata_l`/`m_axis_tvalid_l`, clk_hh domain) and the receiver's external AXI-Stream master port. It accepts decoded bytes without backpressure and buffers them in an internal FIFO. It cuts the stream into packets of a programmable length and drives real `tlast`/`tuser`, where today `tlast` and `tuser` are tied to 0. `tuser` flags packets damaged by a CRC error or by a FIFO overflow; overflow and packet statistics are exported.

## Interface
- pDAT_W, 8, byte width of `idat`/`m_axis_tdata`
- pADDR_W, 6, FIFO address width; depth = 2^pADDR_W (minimum 2, i.e. depth ≥ 4)
- pLEN_W, 12, width of `ipkt_len`
- clk  in  1  clk_hh; the only clock
- rst  in  1  asynchronous, active-low reset
- iflush  in  1  synchronous clear: empties the FIFO, zeroes the byte counter, clears the sticky flags; counters are kept
- ipkt_len  in  pLEN_W  packet length in bytes; 0 is treated as 1
- ival  in  1  DeFEC byte valid; there is no ready, so every pulse is either stored or dropped
- idat  in  pDAT_W  DeFEC byte
- icrc_val  in  1  DeFEC CRC verdict strobe (decrc_verr)
- icrc_err  in  1  CRC error flag, qualified by `icrc_val` (decrc_oerr)
- m_axis_tdata  out  pDAT_W  output byte
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last byte of the packet
- m_axis_tuser  out  1  packet bad; meaningful only on the `tlast` beat
- m_axis_tready  in  1  sink ready
- ovf_cnt  out  16  count of dropped bytes, saturates at 0xFFFF
- pkt_cnt  out  16  count of packets delivered (`tlast` handshakes), wraps

## Operation
- Each FIFO entry holds {user, last, data}, pDAT_W+2 bits. The flag bits live in a register array and can be rewritten in place.
- Byte counter `bcnt`:
  - `len_q` latches `ipkt_len` whenever `bcnt` == 0 and `ival` = 1; mid-packet changes of `ipkt_len` are ignored.
  - On each `ival`, `last` = (`bcnt` == `len_q` − 1). After a last byte `bcnt` returns to 0; otherwise it increments.
  - `bcnt` advances for dropped bytes too, so framing stays aligned to the source.
- Sticky flags:
  - `crc_bad` is set by `icrc_val & icrc_err`.
  - `ovf_bad` is set by any dropped byte.
  - Both clear on the cycle a last byte is accepted or dropped. The clear happens after their OR (including same-cycle events) is captured into that byte's `user` bit.
- Write path: when `ival` = 1 and the FIFO is not full, write {`crc_bad`|`ovf_bad`|same-cycle events, `last`, `idat`}. `user` is forced to 0 on non-last bytes.
- Drop path: when `ival` = 1 and the FIFO is full, the byte is discarded, `ovf_cnt` increments (saturating) and `ovf_bad` is set. If the dropped byte is a last byte:
  - The newest stored entry (address wptr−1) gets last = 1 and user = 1, so the packet still terminates.
  - If that entry is already a last, it gets user = 1 only.
- Full is evaluated from the occupancy at the start of the cycle. A read in the same cycle does not free a slot for a write.
- Read path: the FIFO is show-ahead. `m_axis_*` present the head entry whenever the FIFO is non-empty. A handshake (`tvalid & tready`) pops the entry; `pkt_cnt` increments when the popped beat has `tlast` = 1.
- `iflush` has priority over `ival`/`icrc_val` in the same cycle: the byte and the CRC event are discarded and `ovf_cnt` is not incremented.

## Timing
- Reset (async assert, removal synchronous to `clk`): `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser`, `m_axis_tdata` = 0, `ovf_cnt` = 0, `pkt_cnt` = 0, FIFO empty, `bcnt` = 0, sticky flags = 0. A reset mid-packet loses the partial packet; no `tlast` is emitted for it.
- Latency: an `ival` at edge N into an empty FIFO gives `m_axis_tvalid` = 1 after edge N, i.e. visible in cycle N+1.
- Pop at edge N: the next entry is visible in cycle N+1. Sustained throughput is 1 beat/cycle with `tready` held high.
- `tvalid` never drops without a handshake and `tdata`/`tlast`/`tuser` are stable while `tvalid & !tready`. The one exception: when the head is also the newest entry (occupancy 1), a drop-path rewrite may set its last/user bits while it waits. Occupancy 1 means the FIFO is not full, so this exception can arise only when depth = 1, which the minimum `pADDR_W` excludes.
- Pointers are pADDR_W+1 bits (wrap bit). Full = MSBs differ and the rest are equal; empty = pointers equal.
- Simultaneous write and pop with the FIFO non-full and non-empty: occupancy is unchanged.

## Test plan
- `ipkt_len` = 4, 8 bytes 0x00..0x07 on consecutive cycles, `tready` = 1 → beats 0x00..0x07, `tlast` on 0x03 and 0x07, `tuser` = 0, `pkt_cnt` = 2, first `tvalid` one cycle after the first `ival`.
- `ipkt_len` = 4, `icrc_val & icrc_err` pulsed during byte 1 of packet A → A's `tlast` beat has `tuser` = 1, the following packet B has `tuser` = 0. Repeat with the pulse on the same cycle as the last byte → still flagged on A.
- pADDR_W = 2, `ipkt_len` = 3, `tready` = 0, 9 bytes → 4 stored, `ovf_cnt` = 5. The drop of byte 5 (last of packet 2) rewrites stored byte 3 to last = 1/user = 1. On release, the beats are byte 0, byte 1, byte 2 (tlast, user = 0), byte 3 (tlast, user = 1).
- Random `tready` (50%), `ipkt_len` = 0 → every beat has `tlast`, data order preserved, `tdata` stable under stall.
- `ipkt_len` changed from 4 to 2 after the 2nd byte → the current packet ends at 4 bytes, the next at 2.
- `iflush` mid-packet with 5 entries buffered → `tvalid` = 0 next cycle, `bcnt` = 0, `ovf_cnt`/`pkt_cnt` unchanged. Async `rst` pulsed mid-burst → all outputs 0 immediately.

Source files
------------

// File: rtl/rx_axis_framer_if.sv
// rx_axis_framer_if: AXI-Stream byte channel carrying tlast/tuser packet framing
interface rx_axis_framer_if #(parameter int pDAT_W = 8);
  logic [pDAT_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tuser;
  logic              tready;
  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/rx_axis_framer.sv
// rx_axis_framer: buffers DeFEC bytes in a show-ahead FIFO and frames them into tlast/tuser packets
module rx_axis_framer #(
  parameter int pDAT_W  = 8,
  parameter int pADDR_W = 6,
  parameter int pLEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iflush,
  input  logic [pLEN_W-1:0] ipkt_len,
  input  logic              ival,
  input  logic [pDAT_W-1:0] idat,
  input  logic              icrc_val,
  input  logic              icrc_err,
  rx_axis_framer_if.master  m_axis,
  output logic [15:0]       ovf_cnt,
  output logic [15:0]       pkt_cnt
);
  localparam int DEPTH = 1 << pADDR_W;
  localparam logic [pADDR_W:0]   P_ONE = 1;
  localparam logic [pADDR_W-1:0] A_ONE = 1;
  localparam logic [pLEN_W-1:0]  L_ONE = 1;

  logic [pADDR_W:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [pADDR_W-1:0] waddr, raddr, naddr;
  logic [pDAT_W-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]   last_q, last_d, user_q, user_d;
  logic [pLEN_W-1:0]  bcnt_q, bcnt_d, len_q, len_d, len_cur;
  logic               crc_bad_q, crc_bad_d, ovf_bad_q, ovf_bad_d;
  logic [15:0]        ovf_cnt_q, ovf_cnt_d, pkt_cnt_q, pkt_cnt_d;
  logic               full, empty, wr, drop, crc_ev, is_last, pop, bad;

  always_comb begin
    waddr   = wptr_q[pADDR_W-1:0];
    raddr   = rptr_q[pADDR_W-1:0];
    naddr   = waddr - A_ONE;
    full    = (wptr_q[pADDR_W] != rptr_q[pADDR_W]) && (waddr == raddr);
    empty   = wptr_q == rptr_q;
    // at a packet boundary the live ipkt_len decides this byte's framing
    len_cur = (bcnt_q == '0) ? ((ipkt_len == '0) ? L_ONE : ipkt_len) : len_q;
    is_last = bcnt_q == len_cur - L_ONE;
    wr      = ival & ~full & ~iflush;
    drop    = ival & full & ~iflush;
    crc_ev  = icrc_val & icrc_err & ~iflush;
    bad     = crc_bad_q | ovf_bad_q | crc_ev | drop;
    pop     = ~empty & m_axis.tready;
    wptr_d  = iflush ? '0 : wr ? wptr_q + P_ONE : wptr_q;
    rptr_d  = iflush ? '0 : pop ? rptr_q + P_ONE : rptr_q;
    last_d  = last_q;
    user_d  = user_q;
    if (wr) begin
      last_d[waddr] = is_last;
      user_d[waddr] = is_last & bad;
    end
    // a dropped terminator closes the packet on the newest stored byte instead
    if (drop & is_last) begin
      last_d[naddr] = 1'b1;
      user_d[naddr] = 1'b1;
    end
    bcnt_d    = iflush ? '0 : ival ? (is_last ? '0 : bcnt_q + L_ONE) : bcnt_q;
    len_d     = (ival & ~iflush & (bcnt_q == '0)) ? len_cur : len_q;
    crc_bad_d = ~iflush & ~(ival & is_last) & (crc_bad_q | crc_ev);
    ovf_bad_d = ~iflush & ~(ival & is_last) & (ovf_bad_q | drop);
    ovf_cnt_d = (drop && ovf_cnt_q != 16'hFFFF) ? ovf_cnt_q + 16'd1 : ovf_cnt_q;
    pkt_cnt_d = (pop & last_q[raddr]) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      last_q    <= '0;
      user_q    <= '0;
      bcnt_q    <= '0;
      len_q     <= L_ONE;
      crc_bad_q <= 1'b0;
      ovf_bad_q <= 1'b0;
      ovf_cnt_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      last_q    <= last_d;
      user_q    <= user_d;
      bcnt_q    <= bcnt_d;
      len_q     <= len_d;
      crc_bad_q <= crc_bad_d;
      ovf_bad_q <= ovf_bad_d;
      ovf_cnt_q <= ovf_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[waddr] <= idat;
  end

  assign m_axis.tvalid = ~empty;
  assign m_axis.tdata  = empty ? '0 : mem_q[raddr];
  assign m_axis.tlast  = ~empty & last_q[raddr];
  assign m_axis.tuser  = ~empty & user_q[raddr];
  assign ovf_cnt       = ovf_cnt_q;
  assign pkt_cnt       = pkt_cnt_q;
endmodule

// File: tb/tb_rx_axis_framer.sv
// tb_rx_axis_framer: directed vector table plus hand-written overflow, flush and reset sequences
module tb_rx_axis_framer;
  logic        clk = 1'b0, rst = 1'b0, iflush = 1'b0, ival = 1'b0, icrc_val = 1'b0, icrc_err = 1'b0;
  logic [11:0] ipkt_len = 12'd4;
  logic [7:0]  idat = 8'h00;
  logic [15:0] ovf_a, pkt_a, ovf_b, pkt_b;
  int          errors = 0, checks = 0;

  rx_axis_framer_if #(.pDAT_W(8)) axa ();
  rx_axis_framer_if #(.pDAT_W(8)) axb ();

  always #5 clk = ~clk;

  rx_axis_framer #(.pDAT_W(8), .pADDR_W(6), .pLEN_W(12)) u_a (
    .clk(clk), .rst(rst), .iflush(iflush), .ipkt_len(ipkt_len), .ival(ival), .idat(idat),
    .icrc_val(icrc_val), .icrc_err(icrc_err), .m_axis(axa), .ovf_cnt(ovf_a), .pkt_cnt(pkt_a));

  rx_axis_framer #(.pDAT_W(8), .pADDR_W(2), .pLEN_W(12)) u_b (
    .clk(clk), .rst(rst), .iflush(iflush), .ipkt_len(ipkt_len), .ival(ival), .idat(idat),
    .icrc_val(icrc_val), .icrc_err(icrc_err), .m_axis(axb), .ovf_cnt(ovf_b), .pkt_cnt(pkt_b));

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        ce;
    logic [11:0] len;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic        eu;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic ce, logic [11:0] len,
                              logic ev, logic el, logic eu);
    vec_t r;
    r.v = v; r.d = d; r.ce = ce; r.len = len;
    r.ev = ev; r.ed = ev ? d : 8'h00; r.el = el; r.eu = eu;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic ce);
    ival = v; idat = d; icrc_val = ce; icrc_err = ce;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       pv;
    logic [7:0] pd;
    int         nxt;
    logic [7:0] exp_d [4];
    logic       exp_l [4];
    logic       exp_u [4];
    axa.tready = 1'b0;
    axb.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", axa.tvalid, 1'b0);
    chk("rst_tdata", axa.tdata, 8'h00);
    chk("rst_tlast", axa.tlast, 1'b0);
    chk("rst_tuser", axa.tuser, 1'b0);
    chk("rst_ovf", ovf_a, 16'd0);
    chk("rst_pkt", pkt_a, 16'd0);
    @(negedge clk) rst = 1'b1;

    // contiguous packets, CRC flagging and mid-packet length change, sink always ready
    tbl.push_back(mk(1, 8'h00, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h01, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h03, 0, 4, 1, 1, 0));
    tbl.push_back(mk(1, 8'h04, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h05, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h06, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h07, 0, 4, 1, 1, 0));
    tbl.push_back(mk(1, 8'h10, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h11, 1, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h12, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h13, 0, 4, 1, 1, 1));
    tbl.push_back(mk(1, 8'h14, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h15, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h16, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h17, 0, 4, 1, 1, 0));
    tbl.push_back(mk(1, 8'h20, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h21, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h22, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h23, 1, 4, 1, 1, 1));
    tbl.push_back(mk(1, 8'h24, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h25, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h26, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h27, 0, 4, 1, 1, 0));
    tbl.push_back(mk(1, 8'h30, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h31, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h32, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 8'h33, 0, 2, 1, 1, 0));
    tbl.push_back(mk(1, 8'h34, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 8'h35, 0, 2, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 2, 0, 0, 0));
    axa.tready = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].ce);
      ipkt_len = tbl[i].len;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_tvalid", i), axa.tvalid, tbl[i].ev);
      chk($sformatf("tbl%0d_tdata", i), axa.tdata, tbl[i].ed);
      chk($sformatf("tbl%0d_tlast", i), axa.tlast, tbl[i].el);
      chk($sformatf("tbl%0d_tuser", i), axa.tuser, tbl[i].eu);
    end
    chk("tbl_pkt_cnt", pkt_a, 16'd8);

    // ipkt_len = 0 under random backpressure: every beat is a one-byte packet
    ipkt_len = 12'd0;
    nxt = 0;
    for (int i = 0; i < 130; i++) begin
      drive(i < 30, 8'(8'h40 + i), 1'b0);
      axa.tready = (i < 30) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axa.tvalid) begin
        chk("len0_tlast", axa.tlast, 1'b1);
        chk("len0_tuser", axa.tuser, 1'b0);
      end
      if (axa.tvalid & axa.tready) begin
        chk("len0_order", axa.tdata, 8'(8'h40 + nxt));
        nxt++;
      end
      pv = axa.tvalid & ~axa.tready;
      pd = axa.tdata;
      @(posedge clk);
      #1;
      if (pv) chk("len0_stall_hold", {axa.tvalid, axa.tdata}, {1'b1, pd});
      if (i >= 30 && !axa.tvalid) break;
    end
    chk("len0_beats", nxt, 30);
    chk("len0_pkt_cnt", pkt_a, 16'd38);

    // flush mid-packet with 5 bytes buffered; same-cycle byte and CRC event are discarded
    axa.tready = 1'b0;
    ipkt_len = 12'd8;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h50 + i), 1'b0);
      @(posedge clk);
      #1;
    end
    chk("pre_flush_tdata", axa.tdata, 8'h50);
    iflush = 1'b1;
    drive(1'b1, 8'h55, 1'b1);
    @(posedge clk);
    #1;
    iflush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    chk("flush_tvalid", axa.tvalid, 1'b0);
    chk("flush_ovf", ovf_a, 16'd0);
    chk("flush_pkt", pkt_a, 16'd38);
    ipkt_len = 12'd2;
    axa.tready = 1'b1;
    drive(1'b1, 8'h60, 1'b0);
    @(posedge clk);
    #1;
    chk("post_flush_b0", {axa.tvalid, axa.tdata, axa.tlast, axa.tuser}, {1'b1, 8'h60, 1'b0, 1'b0});
    drive(1'b1, 8'h61, 1'b0);
    @(posedge clk);
    #1;
    chk("post_flush_b1", {axa.tvalid, axa.tdata, axa.tlast, axa.tuser}, {1'b1, 8'h61, 1'b1, 1'b0});
    drive(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    chk("post_flush_pkt", pkt_a, 16'd39);

    // async reset mid-burst clears outputs without waiting for an edge
    axa.tready = 1'b0;
    ipkt_len = 12'd4;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h70 + i), 1'b0);
      @(posedge clk);
      #1;
    end
    #2 rst = 1'b0;
    #1;
    chk("arst_tvalid", axa.tvalid, 1'b0);
    chk("arst_tdata", axa.tdata, 8'h00);
    chk("arst_pkt", pkt_a, 16'd0);
    chk("arst_ovf_small", ovf_b, 16'd0);
    drive(1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // depth-4 FIFO, 3-byte packets, sink stalled: 4 stored, 5 dropped
    axa.tready = 1'b1;
    axb.tready = 1'b0;
    ipkt_len = 12'd3;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("ovf_cnt", ovf_b, 16'd5);
    exp_d[0] = 8'h00; exp_l[0] = 1'b0; exp_u[0] = 1'b0;
    exp_d[1] = 8'h01; exp_l[1] = 1'b0; exp_u[1] = 1'b0;
    exp_d[2] = 8'h02; exp_l[2] = 1'b1; exp_u[2] = 1'b0;
    exp_d[3] = 8'h03; exp_l[3] = 1'b1; exp_u[3] = 1'b1;
    axb.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_beat%0d", i), {axb.tvalid, axb.tdata, axb.tlast, axb.tuser},
          {1'b1, exp_d[i], exp_l[i], exp_u[i]});
      @(posedge clk);
      #1;
    end
    chk("ovf_drained", axb.tvalid, 1'b0);
    chk("ovf_pkt_cnt", pkt_b, 16'd2);
    chk("big_pkt_cnt", pkt_a, 16'd3);
    chk("big_ovf_cnt", ovf_a, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
